decoder_stream: RTL
===================

# decoder_stream

Parametrised, registered SEL_W-to-2^SEL_W one-hot decoder with a valid/ready stream interface and a built-in scan mode that walks the active output across all 2^SEL_W positions. It is the sequential successor to the team's fixed 4-to-16 combinational decoder. It drives chip-select, row-select and test-sweep logic that needs back-pressure and a registered, glitch-free output.

## Interface
- SEL_W, 4, select width; OUT_W = 2**SEL_W (derived, not overridable); legal range 1..8
- ONE_COLD, 0, 1 = active-low outputs: selected bit 0, all others 1
- clk  in  1  rising-edge clock
- rst  in  1  reset; one clock, synchronous and active-high
- in_valid  in  1  direct-decode request
- in_ready  out  1  request accepted when in_valid & in_ready
- in_sel  in  SEL_W  index to decode
- in_en  in  1  0 = emit the inactive pattern (no bit selected) for this beat
- scan_start  in  1  begin scan (sampled only in IDLE)
- scan_stop  in  1  abort scan (sampled only in SCAN)
- scan_busy  out  1  high while in SCAN
- scan_done  out  1  one-cycle pulse when the final scan beat is accepted downstream
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts beat
- out_onehot  out  OUT_W  decoded pattern
- out_idx  out  SEL_W  index carried with the beat

## Operation
- The output register holds a single beat: out_valid, out_onehot, out_idx.
- A beat leaves the register when out_valid & out_ready.
- Register may load when "free": free = ~out_valid | out_ready.
- Decode rule:
  - out_onehot = (1 << idx) if enabled, else all-zero.
  - ONE_COLD=1 applies a bitwise invert after the decode rule.
  - Scan beats are always enabled.
- FSM has two states: IDLE and SCAN. Reset state is IDLE.
- IDLE:
  - in_ready = free & ~scan_start, combinational.
  - Accepted request loads {decode(in_sel, in_en), in_sel} and sets out_valid.
  - scan_start=1 with free=1 moves to SCAN and loads beat idx 0.
  - scan_start=1 with free=0 is held: remain IDLE and re-evaluate each cycle while scan_start stays high. Requesters must hold scan_start until scan_busy rises.
- SCAN:
  - in_ready = 0 and scan_busy = 1.
  - Each cycle with free=1, the next index is loaded, counting 1, 2, ... OUT_W-1.
  - When beat OUT_W-1 is accepted: pulse scan_done, go to IDLE, and leave no pending beat.
  - The counter never wraps inside a scan.
- scan_stop in SCAN:
  - Go to IDLE next cycle; no further scan beats are loaded.
  - A beat already in the register stays valid until accepted.
  - scan_done is not pulsed.
  - scan_stop in IDLE is ignored.
- Simultaneous events:
  - scan_start and in_valid in IDLE: scan wins and the request is not accepted.
  - scan_stop on the same cycle the final beat is accepted: scan_done pulses (completion wins).
- Reset values:
  - out_valid=0, in_ready=0 during rst, scan_busy=0, scan_done=0, out_idx=0.
  - out_onehot is the inactive pattern: all-zero, or all-one for ONE_COLD=1.
  - State = IDLE, counter = 0.
- Reset mid-scan or with a beat pending discards everything. Reset returns the block to the reset values above on the next edge.
- out_onehot and out_idx hold their last value while out_valid=0 and are don't-care in that state.

## Timing
- Latency: request accepted at edge N gives out_valid=1 after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle with out_ready held high; no bubbles between direct requests or between scan beats.
- Full scan: scan_start accepted at edge N puts beat k out after edge N+k. With out_ready=1 throughout, scan_done is high in the cycle following edge N+OUT_W-1 acceptance, and scan_busy falls at the same edge.
- Back-pressure: out_ready=0 freezes the register and the scan counter, and drives in_ready to 0 when out_valid=1.
- All outputs are registered except in_ready, which is combinational from out_valid, out_ready, scan_start and state.

## Test plan
- Direct decode, SEL_W=4, out_ready=1, in_sel=0..15 back-to-back with in_en=1 -> out_onehot = 0x0001..0x8000 in consecutive cycles with matching out_idx. in_sel=5, in_en=0 -> 0x0000.
- ONE_COLD=1, in_sel=3 -> out_onehot=0xFFF7. Under rst, out_onehot=0xFFFF and out_valid=0.
- Scan, out_ready=1: 16 beats 0x0001..0x8000 on 16 consecutive cycles. scan_done pulses once and scan_busy falls together. in_ready=0 throughout the scan.
- Back-pressure: during a scan, drop out_ready for 3 cycles at idx 6 -> beat 0x0040 held stable and no index is skipped or repeated. Then assert scan_stop at idx 9 -> beat 9 delivered, no beat 10, no scan_done.
- Collision: in IDLE, scan_start and in_valid both high with in_sel=7 -> request not accepted, first beat idx 0. With out_valid=1 and out_ready=0, scan_start held 2 cycles -> SCAN entered on the first free cycle.
- Reset mid-scan at idx 4 with a beat pending -> next cycle out_valid=0, scan_busy=0, scan_done=0. A following request with in_sel=2 yields 0x0004 after 1 cycle.

Source files
------------

// File: rtl/decoder_stream_if.sv
// rtl/decoder_stream_if.sv - request, scan-control and output-beat signals of decoder_stream
interface decoder_stream_if #(
  parameter int SEL_W = 4
);
  localparam int OUT_W = 1 << SEL_W;

  logic             in_valid;
  logic             in_ready;
  logic [SEL_W-1:0] in_sel;
  logic             in_en;
  logic             scan_start;
  logic             scan_stop;
  logic             scan_busy;
  logic             scan_done;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_onehot;
  logic [SEL_W-1:0] out_idx;

  modport master (
    output in_valid, in_sel, in_en, scan_start, scan_stop, out_ready,
    input  in_ready, scan_busy, scan_done, out_valid, out_onehot, out_idx
  );

  modport slave (
    input  in_valid, in_sel, in_en, scan_start, scan_stop, out_ready,
    output in_ready, scan_busy, scan_done, out_valid, out_onehot, out_idx
  );
endinterface

// File: rtl/decoder_stream.sv
// rtl/decoder_stream.sv - registered one-hot decoder with valid/ready stream and index scan mode
module decoder_stream #(
  parameter int SEL_W    = 4,
  parameter bit ONE_COLD = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  decoder_stream_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST     = '1;
  localparam logic [OUT_W-1:0] INACTIVE = ONE_COLD ? '1 : '0;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t           state;
  logic [SEL_W-1:0] cnt;
  logic             out_valid_q;
  logic [OUT_W-1:0] out_onehot_q;
  logic [SEL_W-1:0] out_idx_q;
  logic             scan_busy_q;
  logic             scan_done_q;
  logic             free;
  logic             in_ready_c;
  logic             last_taken;

  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] idx, input logic en);
    logic [OUT_W-1:0] p;
    p = '0;
    if (en) p[idx] = 1'b1;
    return ONE_COLD ? ~p : p;
  endfunction

  assign free       = ~out_valid_q | bus.out_ready;
  // A pending scan_start blocks direct requests so the scan wins a collision.
  assign in_ready_c = ~rst & (state == IDLE) & free & ~bus.scan_start;
  assign last_taken = (state == SCAN) & (cnt == LAST) & out_valid_q & bus.out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid_q  <= 1'b0;
      out_onehot_q <= INACTIVE;
      out_idx_q    <= '0;
      scan_busy_q  <= 1'b0;
      scan_done_q  <= 1'b0;
    end else begin
      scan_done_q <= 1'b0;
      if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.scan_start && free) begin
            state        <= SCAN;
            scan_busy_q  <= 1'b1;
            cnt          <= '0;
            out_valid_q  <= 1'b1;
            out_onehot_q <= decode('0, 1'b1);
            out_idx_q    <= '0;
          end else if (bus.in_valid && in_ready_c) begin
            out_valid_q  <= 1'b1;
            out_onehot_q <= decode(bus.in_sel, bus.in_en);
            out_idx_q    <= bus.in_sel;
          end
        end
        SCAN: begin
          // Completion takes priority over a simultaneous stop.
          if (last_taken) begin
            state       <= IDLE;
            scan_busy_q <= 1'b0;
            scan_done_q <= 1'b1;
          end else if (bus.scan_stop) begin
            state       <= IDLE;
            scan_busy_q <= 1'b0;
          end else if (free && cnt != LAST) begin
            cnt          <= cnt + 1'b1;
            out_valid_q  <= 1'b1;
            out_onehot_q <= decode(cnt + 1'b1, 1'b1);
            out_idx_q    <= cnt + 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          scan_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_onehot = out_onehot_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.scan_busy  = scan_busy_q;
  assign bus.scan_done  = scan_done_q;
endmodule
